rate_mult_gen: RTL and testbench

- Parametrised binary rate multiplier (BRM); successor to the fixed 8-bit fractional-rate pulse generator.
- Over each period of 2^WIDTH enabled cycles, emits exactly `rate` output pulses, spread using the standard trailing-ones weighting.
- New relative to the old block:
  - parametrised width;
  - registered, glitch-free output;
  - shadowed rate register, applied only at period boundaries;
  - start/stop control with one-shot mode;
  - terminal-count output for cascading.
- Sits in the clock/timing cluster, feeding rate-controlled strobes to downstream counters.

---
 rtl/rate_mult_gen.sv | 149 ++++++++++++++
 tb/tb_rate_mult_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rate_mult_gen.sv
// Parametrised binary rate multiplier: emits exactly `rate` registered pulses per
// 2^WIDTH enabled cycles, with shadowed rate, start/stop/one-shot control and terminal count.
module rate_mult_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             rate_load,
    input  logic [WIDTH-1:0] rate_in,
    output logic             pz,
    output logic             tc,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] cnt_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Trailing-ones weighting: the first zero bit of c (from the LSB) at position t
    // selects rate bit WIDTH-1-t, so the MSB of rate fires on half the counts.
    function automatic logic brm_select(input logic [WIDTH-1:0] c,
                                        input logic [WIDTH-1:0] r);
        logic hit;
        logic searching;
        hit       = 1'b0;
        searching = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (searching && !c[i]) begin
                hit       = r[WIDTH-1-i];
                searching = 1'b0;
            end
        end
        return hit;
    endfunction

    state_t           state_r;
    state_t           state_n_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_n_s;
    logic [WIDTH-1:0] rate_pend_r;
    logic [WIDTH-1:0] rate_act_r;
    logic [WIDTH-1:0] rate_act_n_s;
    logic [WIDTH-1:0] rate_src_s;
    logic             mode_os_r;
    logic             mode_os_n_s;
    logic             p_s;
    logic             tc_s;
    logic             done_s;
    logic             pz_r;
    logic             tc_r;
    logic             done_r;
    logic             busy_r;

    // A same-cycle load bypasses the pending register so the new rate is never lost.
    assign rate_src_s = rate_load ? rate_in : rate_pend_r;

    // Next-state, counter, active-rate and pre-register output decode.
    always_comb begin
        state_n_s    = state_r;
        cnt_n_s      = cnt_r;
        rate_act_n_s = rate_act_r;
        mode_os_n_s  = mode_os_r;
        p_s          = 1'b0;
        tc_s         = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n_s      = ZERO;
                rate_act_n_s = rate_src_s;
                if (start && !stop) begin
                    state_n_s   = ST_RUN;
                    mode_os_n_s = oneshot;
                end else begin
                    state_n_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = ZERO;
                end else if (en) begin
                    if (cnt_r == ALL_ONES) begin
                        tc_s         = 1'b1;
                        cnt_n_s      = ZERO;
                        rate_act_n_s = rate_src_s;
                        if (mode_os_r) begin
                            done_s    = 1'b1;
                            state_n_s = ST_IDLE;
                        end else begin
                            state_n_s = ST_RUN;
                        end
                    end else begin
                        p_s     = brm_select(cnt_r, rate_act_r);
                        cnt_n_s = cnt_r + ONE;
                    end
                end else begin
                    cnt_n_s = cnt_r;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = ZERO;
            end
        endcase
    end

    // State, counter, rate registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= ZERO;
            rate_pend_r <= ZERO;
            rate_act_r  <= ZERO;
            mode_os_r   <= 1'b0;
            pz_r        <= 1'b0;
            tc_r        <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            rate_pend_r <= rate_src_s;
            rate_act_r  <= rate_act_n_s;
            mode_os_r   <= mode_os_n_s;
            pz_r        <= p_s;
            tc_r        <= tc_s;
            done_r      <= done_s;
            busy_r      <= (state_n_s == ST_RUN);
        end
    end

    assign pz      = pz_r;
    assign tc      = tc_r;
    assign done    = done_r;
    assign busy    = busy_r;
    assign cnt_out = cnt_r;

endmodule

// File: tb/tb_rate_mult_gen.sv
// Scoreboard bench for rate_mult_gen (WIDTH=4): directed phases push expected output
// events; a negedge monitor pops and compares whenever pz, tc or done is high.
module tb_rate_mult_gen;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         en;
    logic         start;
    logic         stop;
    logic         oneshot;
    logic         rate_load;
    logic [W-1:0] rate_in;
    logic         pz;
    logic         tc;
    logic         done;
    logic         busy;
    logic [W-1:0] cnt_out;

    typedef struct packed {
        logic         pz;
        logic         tc;
        logic         done;
        logic         busy;
        logic [W-1:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    rate_mult_gen #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .rate_load (rate_load),
        .rate_in   (rate_in),
        .pz        (pz),
        .tc        (tc),
        .done      (done),
        .busy      (busy),
        .cnt_out   (cnt_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse from counting cycle c is seen one cycle later, when cnt_out is c+1.
    task automatic push_pulses(input logic [15:0] mask, input int upto);
        ev_t e;
        for (int c = 0; c < upto; c++) begin
            if (mask[c]) begin
                e = {1'b1, 1'b0, 1'b0, 1'b1, 4'(c + 1)};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_wrap(input logic dn, input logic bz);
        ev_t e;
        e = {1'b0, 1'b1, dn, bz, 4'd0};
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle presenting an output event is matched against the scoreboard.
    always @(negedge clock) begin
        ev_t act;
        ev_t e;
        if ((pz | tc | done) === 1'b1) begin
            act = {pz, tc, done, busy, cnt_out};
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got %0h expected none", act);
            end else begin
                e = exp_q.pop_front();
                chk("event", 32'(act), 32'(e));
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b1; start = 1'b1; stop = 1'b0;
        oneshot = 1'b0; rate_load = 1'b1; rate_in = 4'd5;
        repeat (4) begin
            tick();
            chk("reset_outputs", 32'({pz, tc, done, busy, cnt_out}), 32'd0);
        end
        reset = 1'b0; en = 1'b0; start = 1'b0; rate_load = 1'b0; rate_in = 4'd0;
        repeat (2) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pz", 32'(pz), 32'd0);
        end

        // One-shot, rate 5: pulses after c=1,5,7,9,13; tc+done after c=15.
        rate_load = 1'b1; rate_in = 4'd5;
        tick();
        rate_load = 1'b0;
        push_pulses(16'h22A2, 15);
        push_wrap(1'b1, 1'b0);
        start = 1'b1; oneshot = 1'b1; en = 1'b1;
        tick();
        start = 1'b0; oneshot = 1'b0;
        chk("p1_busy_start", 32'(busy), 32'd1);
        chk("p1_cnt_start", 32'(cnt_out), 32'd0);
        tick();
        chk("p1_cnt_first", 32'(cnt_out), 32'd1);
        repeat (15) tick();
        chk("p1_tc_done_busy", 32'({tc, done, busy}), 32'h6);
        en = 1'b0;
        tick();
        chk("p1_done_one_cycle", 32'(done), 32'd0);
        chk("p1_q_empty", 32'(exp_q.size()), 32'd0);

        // Continuous, rate 15 loaded together with start: two periods.
        repeat (2) begin
            push_pulses(16'h7FFF, 15);
            push_wrap(1'b0, 1'b1);
        end
        rate_load = 1'b1; rate_in = 4'd15; start = 1'b1; oneshot = 1'b0; en = 1'b1;
        tick();
        rate_load = 1'b0; start = 1'b0;
        repeat (32) tick();
        chk("p2_busy_running", 32'(busy), 32'd1);
        chk("p2_cnt_wrapped", 32'(cnt_out), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("p2_stop_state", 32'({busy, pz, cnt_out}), 32'd0);
        en = 1'b0;
        tick();
        chk("p2_q_empty", 32'(exp_q.size()), 32'd0);

        // Continuous rate 5, load 8 at c=6: takes effect only in the next period.
        push_pulses(16'h22A2, 15);
        push_wrap(1'b0, 1'b1);
        push_pulses(16'h5555, 15);
        push_wrap(1'b0, 1'b1);
        rate_load = 1'b1; rate_in = 4'd5; start = 1'b1; en = 1'b1;
        tick();
        rate_load = 1'b0; start = 1'b0;
        repeat (6) tick();
        rate_load = 1'b1; rate_in = 4'd8;
        tick();
        rate_load = 1'b0;
        repeat (25) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0; en = 1'b0;
        tick();
        chk("p3_q_empty", 32'(exp_q.size()), 32'd0);

        // One-shot rate 15 with en toggling 1,0,1,0: 32 clocks per period.
        push_pulses(16'h7FFF, 15);
        push_wrap(1'b1, 1'b0);
        rate_load = 1'b1; rate_in = 4'd15; start = 1'b1; oneshot = 1'b1; en = 1'b1;
        tick();
        rate_load = 1'b0; start = 1'b0; oneshot = 1'b0;
        for (int i = 0; i < 32; i++) begin
            en = (i % 2 == 0);
            tick();
            if (i == 9) chk("p4_cnt_half_rate", 32'(cnt_out), 32'd5);
        end
        chk("p4_busy_end", 32'(busy), 32'd0);
        en = 1'b0;
        tick();
        chk("p4_q_empty", 32'(exp_q.size()), 32'd0);

        // Stop at c=9: pulses before it only, no tc/done.
        push_pulses(16'h22A2, 9);
        rate_load = 1'b1; rate_in = 4'd5; start = 1'b1; oneshot = 1'b1; en = 1'b1;
        tick();
        rate_load = 1'b0; start = 1'b0; oneshot = 1'b0;
        repeat (9) tick();
        chk("p5_cnt_before_stop", 32'(cnt_out), 32'd9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("p5_after_stop", 32'({pz, tc, done, busy, cnt_out}), 32'd0);
        repeat (3) tick();
        chk("p5_q_empty", 32'(exp_q.size()), 32'd0);

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1; en = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("p6_busy", 32'(busy), 32'd0);
        tick();
        chk("p6_idle_hold", 32'({busy, cnt_out}), 32'd0);

        // Rate 0 continuous for two periods; a start mid-run is ignored.
        push_wrap(1'b0, 1'b1);
        push_wrap(1'b0, 1'b1);
        rate_load = 1'b1; rate_in = 4'd0; start = 1'b1; oneshot = 1'b0; en = 1'b1;
        tick();
        rate_load = 1'b0; start = 1'b0;
        repeat (3) tick();
        start = 1'b1; oneshot = 1'b1;
        tick();
        start = 1'b0; oneshot = 1'b0;
        chk("p7_start_ignored", 32'({busy, cnt_out}), 32'h14);
        repeat (28) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0; en = 1'b0;
        repeat (2) tick();
        chk("p7_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
